// File: rtl/fpu_dp_accumulator.sv
// Purpose : sequential sum-of-N stage that folds a stream of binary64 operands
//           into a running sum through an external combinational adder.
// Latency : one operand per cycle; sum_valid rises the cycle after the len-th beat
//           (the cycle after start for a len==0 job).
// Backpressure: in_ready is high only while accumulating; the final sum and its
//           flags are held with sum_valid until sum_ready is seen.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   start, len                    launch a job of len operands (sampled in IDLE)
//   in_valid/in_ready/in_data     operand handshake
//   add_a, add_b                  adder operands (running sum, current operand)
//   add_result/overflow/underflow adder outputs, combinational from add_a/add_b
//   sum_valid/sum_ready/sum       result handshake and sum register
//   sum_overflow, sum_underflow   sticky exception flags for the job
//   count, busy                   operands accepted; state is not IDLE
module fpu_dp_accumulator #(
  parameter int WIDTH   = 64,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_result,
  input  logic               add_overflow,
  input  logic               add_underflow,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               sum_overflow,
  output logic               sum_underflow,
  output logic [COUNT_W-1:0] count,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         state;
  logic [COUNT_W-1:0] remaining;
  logic               beat;

  // The adder sits in a single-cycle loop: sum -> add_a -> add_result -> sum.
  assign add_a = sum;
  assign add_b = in_data;

  assign in_ready  = (state == ST_ACCUM);
  assign sum_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign beat      = in_ready && in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      sum           <= '0;
      count         <= '0;
      remaining     <= '0;
      sum_overflow  <= 1'b0;
      sum_underflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // +0.0 is the additive identity, so the first beat yields the operand.
            sum           <= '0;
            count         <= '0;
            remaining     <= len;
            sum_overflow  <= 1'b0;
            sum_underflow <= 1'b0;
            state         <= (len == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            sum           <= add_result;
            sum_overflow  <= sum_overflow  | add_overflow;
            sum_underflow <= sum_underflow | add_underflow;
            count         <= count + 1'b1;
            remaining     <= remaining - 1'b1;
            if (remaining == COUNT_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here, even on the handshake cycle.
          if (sum_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dp_accumulator.sv
// Purpose : self-checking bench for fpu_dp_accumulator with a behavioural
//           binary64 adder closing the sum loop and a scoreboard of job results.
module tb_fpu_dp_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [63:0] add_result;
  logic        add_overflow;
  logic        add_underflow;
  logic        sum_valid;
  logic        sum_ready;
  logic [63:0] sum;
  logic        sum_overflow;
  logic        sum_underflow;
  logic [15:0] count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] sum;
    logic        ovf;
    logic        unf;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  fpu_dp_accumulator #(.WIDTH(64), .COUNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_result    (add_result),
    .add_overflow  (add_overflow),
    .add_underflow (add_underflow),
    .sum_valid     (sum_valid),
    .sum_ready     (sum_ready),
    .sum           (sum),
    .sum_overflow  (sum_overflow),
    .sum_underflow (sum_underflow),
    .count         (count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: overflow when finite operands produce an infinity,
  // underflow when the result is subnormal.
  always_comb begin
    add_result    = $realtobits($bitstoreal(add_a) + $bitstoreal(add_b));
    add_overflow  = (add_result[62:52] == 11'h7ff) && (add_a[62:52] != 11'h7ff) &&
                    (add_b[62:52] != 11'h7ff);
    add_underflow = (add_result[62:52] == 11'h000) && (add_result[51:0] != 52'h0);
  end

  // Inputs change and outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [15:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!sum_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: sum_valid seen with no expected job");
    end else begin
      e = sb.pop_front();
      checks++;
      if (sum !== e.sum) begin
        errors++;
        $display("FAIL sum: got %h expected %h", sum, e.sum);
      end
      checks++;
      if (sum_overflow !== e.ovf || sum_underflow !== e.unf) begin
        errors++;
        $display("FAIL flags: got ovf=%b unf=%b expected ovf=%b unf=%b",
                 sum_overflow, sum_underflow, e.ovf, e.unf);
      end
      checks++;
      if (count !== e.cnt) begin
        errors++;
        $display("FAIL count: got %0d expected %0d", count, e.cnt);
      end
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: sum_valid=%b busy=%b expected 0 0", sum_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || sum_valid !== 1'b0 || busy !== 1'b0 || sum !== 64'h0 ||
        count !== 16'h0 || sum_overflow !== 1'b0 || sum_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b sum_valid=%b busy=%b sum=%h count=%0d ovf=%b unf=%b expected all zero",
               in_ready, sum_valid, busy, sum, count, sum_overflow, sum_underflow);
    end
  endtask

  task automatic test_back_to_back();
    real ops[2] = '{4.20, 3.20};
    int  n;
    sb.push_back('{$realtobits(4.20 + 3.20), 1'b0, 1'b0, 16'd2});
    launch(16'd2);
    foreach (ops[i]) begin
      in_valid = 1'b1;
      in_data  = $realtobits(ops[i]);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready beat %0d: got %b expected 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL b2b_latency: sum_valid after %0d extra cycles expected 0", n);
    end
    consume();
  endtask

  task automatic test_gaps();
    real         ops[3] = '{2234.0132, -1235.3412, 1.0132};
    logic [63:0] held;
    int          n;
    sb.push_back('{$realtobits((2234.0132 + -1235.3412) + 1.0132), 1'b0, 1'b0, 16'd3});
    launch(16'd3);
    foreach (ops[i]) begin
      in_valid = 1'b0;
      in_data  = 64'h4059_0000_0000_0000;
      held     = sum;
      for (int g = 0; g < 2; g++) begin
        tick();
        checks++;
        if (in_ready !== 1'b1 || sum !== held || count !== 16'(i)) begin
          errors++;
          $display("FAIL gap_hold beat %0d: in_ready=%b sum=%h count=%0d expected 1 %h %0d",
                   i, in_ready, sum, count, held, i);
        end
      end
      in_valid = 1'b1;
      in_data  = $realtobits(ops[i]);
      tick();
    end
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL gap_latency: sum_valid after %0d extra cycles expected 0", n);
    end
    consume();
  endtask

  task automatic test_overflow();
    logic [63:0] ops[3] = '{64'h7fef_ffff_ffff_ffff, 64'h7fef_ffff_ffff_ffff, 64'h3ff0_0000_0000_0000};
    int          n;
    sb.push_back('{64'h7ff0_0000_0000_0000, 1'b1, 1'b0, 16'd3});
    launch(16'd3);
    foreach (ops[i]) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      tick();
    end
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL ovf_latency: sum_valid after %0d extra cycles expected 0", n);
    end
    consume();
  endtask

  task automatic test_underflow();
    logic [63:0] ops[2] = '{64'h0000_0000_0000_1000, 64'h3ff0_0000_0000_0000};
    int          n;
    sb.push_back('{64'h3ff0_0000_0000_0000, 1'b0, 1'b1, 16'd2});
    launch(16'd2);
    foreach (ops[i]) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      tick();
    end
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL unf_latency: sum_valid after %0d extra cycles expected 0", n);
    end
    consume();
  endtask

  task automatic test_zero_len();
    sb.push_back('{64'h0, 1'b0, 1'b0, 16'd0});
    launch(16'd0);
    checks++;
    if (sum_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: sum_valid=%b in_ready=%b expected 1 0", sum_valid, in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (sum_valid !== 1'b1 || sum !== 64'h0) begin
        errors++;
        $display("FAIL zero_len_hold cycle %0d: sum_valid=%b sum=%h expected 1 0", k, sum_valid, sum);
      end
    end
    consume();
  endtask

  task automatic test_reset_midjob();
    in_data = 64'h3ff0_0000_0000_0000;
    launch(16'd4);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || sum !== 64'h0 || count !== 16'h0 ||
        sum_overflow !== 1'b0 || sum_underflow !== 1'b0) begin
      errors++;
      $display("FAIL midjob_reset: busy=%b in_ready=%b sum=%h count=%0d expected 0 0 0 0",
               busy, in_ready, sum, count);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sum_valid !== 1'b0) begin
        errors++;
        $display("FAIL midjob_no_valid cycle %0d: sum_valid=%b expected 0", k, sum_valid);
      end
      tick();
    end
    sb.push_back('{$realtobits(6.40), 1'b0, 1'b0, 16'd1});
    launch(16'd1);
    in_valid = 1'b1;
    in_data  = $realtobits(6.40);
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_job: sum_valid=%b expected 1", sum_valid);
    end
    consume();
  endtask

  task automatic test_start_ignored();
    logic [63:0] held;
    int          n;
    sb.push_back('{$realtobits((1.5 + 2.5) + 3.0), 1'b0, 1'b0, 16'd3});
    launch(16'd3);
    in_valid = 1'b1;
    in_data  = $realtobits(1.5);
    tick();
    in_valid = 1'b0;
    held     = sum;
    start    = 1'b1;
    len      = 16'd7;
    tick();
    start    = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || sum !== held || count !== 16'd1) begin
      errors++;
      $display("FAIL start_in_accum: in_ready=%b sum=%h count=%0d expected 1 %h 1",
               in_ready, sum, count, held);
    end
    in_valid = 1'b1;
    in_data  = $realtobits(2.5);
    tick();
    in_data  = $realtobits(3.0);
    tick();
    in_valid = 1'b0;
    // If the ACCUM start had reloaded the length, sum_valid would still be low.
    wait_valid(n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL start_accum_remaining: sum_valid after %0d extra cycles expected 0", n);
    end
    held  = sum;
    start = 1'b1;
    len   = 16'd0;
    tick();
    checks++;
    if (sum_valid !== 1'b1 || sum !== held || count !== 16'd3) begin
      errors++;
      $display("FAIL start_in_done: sum_valid=%b sum=%h count=%0d expected 1 %h 3",
               sum_valid, sum, count, held);
    end
    len = 16'd5;
    consume();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_on_return: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = 16'd0;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    sum_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_underflow();
    test_zero_len();
    test_reset_midjob();
    test_start_ignored();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d results never produced expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
